xfer_seq: RTL and testbench

XFER_SEQ -- requirements
Module: xfer_seq

---
 rtl/xfer_seq.sv | 129 ++++++++++++
 tb/tb_xfer_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/xfer_seq.sv
// xfer_seq -- REU DMA transfer sequencer.
// Steps one byte at a time through the stash / fetch / swap / verify access
// pattern, one state per PHI2 cycle, updating on the falling PHI2 edge.
// Address and length bookkeeping live in the register block; this block only
// emits the access strobes and the per-byte advance / end / error pulses.
//
// Ports:
//   PHI2        in   system clock (falling edge active)
//   Reset       in   asynchronous active-high reset
//   Execute     in   command register execute bit (level)
//   FF00Decode  in   defer start until CPU write to $FF00
//   FF00Hit     in   CPU write to $FF00 this cycle
//   XferType    in   00 stash, 01 fetch, 10 swap, 11 verify
//   Length1     in   transfer length register equals 1
//   BA          in   bus available (0 = stall)
//   CD, RD      in   C64 / REU RAM read data
//   DMA         out  request C64 bus
//   C64RD, C64WR, RAMRD, RAMWR  out  access strobes
//   WD          out  write data for C64WR / RAMWR
//   NextCA, NextREUA, XferEnd, VerifyErr  out  one-cycle pulses
//   Busy        out  sequencer not idle
module xfer_seq (
   input  logic       PHI2,
   input  logic       Reset,
   input  logic       Execute,
   input  logic       FF00Decode,
   input  logic       FF00Hit,
   input  logic [1:0] XferType,
   input  logic       Length1,
   input  logic       BA,
   input  logic [7:0] CD,
   input  logic [7:0] RD,
   output logic       DMA,
   output logic       C64RD,
   output logic       C64WR,
   output logic       RAMRD,
   output logic       RAMWR,
   output logic [7:0] WD,
   output logic       NextCA,
   output logic       NextREUA,
   output logic       XferEnd,
   output logic       VerifyErr,
   output logic       Busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_RDC, S_RDR, S_WRC, S_WRR, S_ADV, S_VERR
   } state_t;

   state_t     state_q, state_d;
   state_t     first_s;
   logic [7:0] latch_a_q, latch_a_d;
   logic [7:0] latch_b_q, latch_b_d;

   // Only fetch begins on the REU side; every other type reads the C64 first.
   assign first_s = (XferType == 2'b01) ? S_RDR : S_RDC;

   always_comb begin
      state_d   = state_q;
      latch_a_d = latch_a_q;
      latch_b_d = latch_b_q;
      case (state_q)
         S_IDLE: begin
            if (Execute) state_d = FF00Decode ? S_ARM : first_s;
         end
         S_ARM: begin
            if (FF00Hit)       state_d = first_s;
            else if (!Execute) state_d = S_IDLE;
         end
         S_RDC: begin
            if (BA) begin
               latch_a_d = CD;
               state_d   = (XferType == 2'b00) ? S_WRR : S_RDR;
            end
         end
         S_RDR: begin
            if (BA) begin
               latch_b_d = RD;
               case (XferType)
                  // compare against the live RD: LatchB only takes it on this edge
                  2'b11:   state_d = (latch_a_q == RD) ? S_ADV : S_VERR;
                  2'b00:   state_d = S_WRR;
                  default: state_d = S_WRC;
               endcase
            end
         end
         S_WRC: begin
            if (BA) state_d = (XferType == 2'b10) ? S_WRR : S_ADV;
         end
         S_WRR: begin
            if (BA) state_d = S_ADV;
         end
         S_ADV:   state_d = Length1 ? S_IDLE : first_s;
         S_VERR:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(negedge PHI2 or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         latch_a_q <= '0;
         latch_b_q <= '0;
      end else begin
         state_q   <= state_d;
         latch_a_q <= latch_a_d;
         latch_b_q <= latch_b_d;
      end
   end

   // Moore decodes of the registered state; strobes gated by BA so a stalled
   // cycle issues no access.
   always_comb begin
      DMA       = (state_q != S_IDLE) && (state_q != S_ARM);
      Busy      = (state_q != S_IDLE);
      C64RD     = (state_q == S_RDC) && BA;
      RAMRD     = (state_q == S_RDR) && BA;
      C64WR     = (state_q == S_WRC) && BA;
      RAMWR     = (state_q == S_WRR) && BA;
      NextCA    = (state_q == S_ADV);
      NextREUA  = (state_q == S_ADV);
      XferEnd   = (state_q == S_ADV) && Length1;
      VerifyErr = (state_q == S_VERR);
      WD        = '0;
      if (state_q == S_WRC)      WD = latch_b_q;
      else if (state_q == S_WRR) WD = latch_a_q;
   end

endmodule

// File: tb/tb_xfer_seq.sv
module tb_xfer_seq;

   logic       PHI2, Reset, Execute, FF00Decode, FF00Hit, Length1, BA;
   logic [1:0] XferType;
   logic [7:0] CD, RD, WD;
   logic       DMA, C64RD, C64WR, RAMRD, RAMWR;
   logic       NextCA, NextREUA, XferEnd, VerifyErr, Busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Output bit positions in the packed observation vector.
   localparam logic [9:0] O_DMA  = 10'b10_0000_0000;
   localparam logic [9:0] O_CRD  = 10'b01_0000_0000;
   localparam logic [9:0] O_RRD  = 10'b00_1000_0000;
   localparam logic [9:0] O_CWR  = 10'b00_0100_0000;
   localparam logic [9:0] O_RWR  = 10'b00_0010_0000;
   localparam logic [9:0] O_NCA  = 10'b00_0001_0000;
   localparam logic [9:0] O_NRA  = 10'b00_0000_1000;
   localparam logic [9:0] O_END  = 10'b00_0000_0100;
   localparam logic [9:0] O_VERR = 10'b00_0000_0010;
   localparam logic [9:0] O_BUSY = 10'b00_0000_0001;
   localparam logic [9:0] ACT    = O_DMA | O_BUSY;
   localparam logic [9:0] ADVB   = ACT | O_NCA | O_NRA;

   xfer_seq dut (
      .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .FF00Decode(FF00Decode),
      .FF00Hit(FF00Hit), .XferType(XferType), .Length1(Length1), .BA(BA),
      .CD(CD), .RD(RD), .DMA(DMA), .C64RD(C64RD), .C64WR(C64WR),
      .RAMRD(RAMRD), .RAMWR(RAMWR), .WD(WD), .NextCA(NextCA),
      .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr), .Busy(Busy)
   );

   initial PHI2 = 1'b1;
   always #5 PHI2 = ~PHI2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input logic [9:0] exp, input logic [7:0] exp_wd);
      check(tag, {22'd0, DMA, C64RD, RAMRD, C64WR, RAMWR, NextCA, NextREUA,
                  XferEnd, VerifyErr, Busy}, {22'd0, exp});
      check({tag, "_wd"}, {24'd0, WD}, {24'd0, exp_wd});
   endtask

   // Advance past the next active (falling) edge and settle.
   task automatic tick();
      @(negedge PHI2);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Execute = 1'b0; FF00Decode = 1'b0; FF00Hit = 1'b0;
      XferType = 2'b00; Length1 = 1'b0; BA = 1'b1; CD = '0; RD = '0;
      #12;
      expect_outs("reset", 10'd0, 8'h00);
      Reset = 1'b0;
      tick();
      expect_outs("idle_hold", 10'd0, 8'h00);

      // Stash two bytes
      XferType = 2'b00; Execute = 1'b1; CD = 8'h5A; Length1 = 1'b0;
      tick(); expect_outs("st_rdc0", ACT | O_CRD, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("st_wrr0", ACT | O_RWR, 8'h5A);
      CD = 8'hA5;
      tick(); expect_outs("st_adv0", ADVB, 8'h00);
      tick(); expect_outs("st_rdc1", ACT | O_CRD, 8'h00);
      Length1 = 1'b1;
      tick(); expect_outs("st_wrr1", ACT | O_RWR, 8'hA5);
      tick(); expect_outs("st_adv1", ADVB | O_END, 8'h00);
      tick(); expect_outs("st_idle", 10'd0, 8'h00);

      // Fetch deferred by $FF00
      XferType = 2'b01; Execute = 1'b1; FF00Decode = 1'b1; RD = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         tick(); expect_outs($sformatf("fe_arm%0d", i), O_BUSY, 8'h00);
      end
      FF00Hit = 1'b1;
      tick(); expect_outs("fe_rdr", ACT | O_RRD, 8'h00);
      FF00Hit = 1'b0; Execute = 1'b0; FF00Decode = 1'b0;
      tick(); expect_outs("fe_wrc", ACT | O_CWR, 8'hC3);
      tick(); expect_outs("fe_adv", ADVB | O_END, 8'h00);
      tick(); expect_outs("fe_idle", 10'd0, 8'h00);

      // ARM abandoned when Execute drops
      Execute = 1'b1; FF00Decode = 1'b1;
      tick(); expect_outs("arm_in", O_BUSY, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("arm_abort", 10'd0, 8'h00);
      FF00Decode = 1'b0;

      // Swap single byte
      XferType = 2'b10; Execute = 1'b1; CD = 8'h11; RD = 8'h22; Length1 = 1'b1;
      tick(); expect_outs("sw_rdc", ACT | O_CRD, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("sw_rdr", ACT | O_RRD, 8'h00);
      tick(); expect_outs("sw_wrc", ACT | O_CWR, 8'h22);
      tick(); expect_outs("sw_wrr", ACT | O_RWR, 8'h11);
      tick(); expect_outs("sw_adv", ADVB | O_END, 8'h00);
      tick(); expect_outs("sw_idle", 10'd0, 8'h00);

      // Verify mismatch, then match
      XferType = 2'b11; Execute = 1'b1; CD = 8'h33; RD = 8'h34; Length1 = 1'b0;
      tick(); expect_outs("vf_rdc", ACT | O_CRD, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("vf_rdr", ACT | O_RRD, 8'h00);
      tick(); expect_outs("vf_verr", ACT | O_VERR, 8'h00);
      tick(); expect_outs("vf_idle", 10'd0, 8'h00);
      Execute = 1'b1; RD = 8'h33; Length1 = 1'b1;
      tick(); expect_outs("vm_rdc", ACT | O_CRD, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("vm_rdr", ACT | O_RRD, 8'h00);
      tick(); expect_outs("vm_adv", ADVB | O_END, 8'h00);
      tick(); expect_outs("vm_idle", 10'd0, 8'h00);

      // BA stalls in RDC and WRR
      XferType = 2'b00; Execute = 1'b1; CD = 8'hEE; BA = 1'b0;
      tick(); expect_outs("ba_rdc_stall", ACT, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("ba_rdc_hold", ACT, 8'h00);
      BA = 1'b1; CD = 8'h77;
      tick(); expect_outs("ba_wrr", ACT | O_RWR, 8'h77);
      BA = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         expect_outs($sformatf("ba_wrr_stall%0d", i), ACT, 8'h77);
         tick();
      end
      expect_outs("ba_wrr_stall3", ACT, 8'h77);
      BA = 1'b1; #1;
      expect_outs("ba_wrr_go", ACT | O_RWR, 8'h77);
      tick(); expect_outs("ba_adv", ADVB | O_END, 8'h00);
      tick(); expect_outs("ba_idle", 10'd0, 8'h00);

      // Async reset mid-RDR
      XferType = 2'b01; Execute = 1'b1; RD = 8'h99;
      tick(); expect_outs("rst_rdr", ACT | O_RRD, 8'h00);
      #2 Reset = 1'b1;
      #1 expect_outs("rst_async", 10'd0, 8'h00);
      check("rst_latch_b", {24'd0, dut.latch_b_q}, 32'd0);
      check("rst_latch_a", {24'd0, dut.latch_a_q}, 32'd0);
      // Release between edges with Execute held: start on the next falling edge
      XferType = 2'b00; CD = 8'h42;
      #1 Reset = 1'b0;
      #1 expect_outs("rst_rel_idle", 10'd0, 8'h00);
      tick(); expect_outs("rst_rel_rdc", ACT | O_CRD, 8'h00);
      Execute = 1'b0;
      tick(); expect_outs("rst_rel_wrr", ACT | O_RWR, 8'h42);
      tick(); expect_outs("rst_rel_adv", ADVB | O_END, 8'h00);
      tick(); expect_outs("rst_rel_idle2", 10'd0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
